// File: rtl/alu_tile_arb_pkg.sv
// alu_tile_arb_pkg
// Shared types for the ALU tile issue arbiter: requester index enum,
// packet struct, default widths and the round-robin wrap helper.
package alu_tile_arb_pkg;

    localparam int ARB_DATA_W = 64;
    localparam int ARB_CTRL_W = 16;
    localparam int NUM_PORTS  = 5;

    typedef enum logic [2:0] {
        PORT_N    = 3'd0,
        PORT_E    = 3'd1,
        PORT_S    = 3'd2,
        PORT_W    = 3'd3,
        PORT_HOST = 3'd4
    } port_e;

    typedef struct packed {
        logic [ARB_DATA_W-1:0] a;
        logic [ARB_DATA_W-1:0] b;
        logic [ARB_CTRL_W-1:0] ctrl;
    } alu_pkt_t;

    // Next requester index in search order, wrapping 4 -> 0.
    function automatic logic [2:0] rr_next(input logic [2:0] p);
        return (p >= 3'(PORT_HOST)) ? 3'(PORT_N) : p + 3'd1;
    endfunction

endpackage

// File: rtl/alu_tile_issue_arbiter_rr_pick5.sv
// rr_pick5
// Combinational 5-way round-robin picker. The search starts at the
// requester after ptr_i and wraps from 4 to 0; the first requester wins.
//   req_i     : request vector, one bit per requester
//   ptr_i     : index of the last granted requester
//   gnt_o     : one-hot grant
//   gnt_idx_o : index of the granted requester
//   any_o     : at least one request present
module rr_pick5 (
    input  logic [4:0] req_i,
    input  logic [2:0] ptr_i,
    output logic [4:0] gnt_o,
    output logic [2:0] gnt_idx_o,
    output logic       any_o
);
    import alu_tile_arb_pkg::*;

    logic [2:0] cand;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        cand      = ptr_i;
        for (int i = 0; i < 5; i++) begin
            cand = rr_next(cand);
            if (!any_o && req_i[cand]) begin
                gnt_o[cand] = 1'b1;
                gnt_idx_o   = cand;
                any_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_tile_issue_arbiter.sv
// alu_tile_issue_arbiter
// Shares the single operand-issue port of one ALU tile among the four mesh
// directions (N/E/S/W) and the host. Each requester has a 1-entry holding
// buffer; a round-robin picker moves one buffered packet per cycle into a
// registered issue stage. Packets pass through bit-exact.
// Ports:
//   clk, rst_n                     : tile clock, async active-low reset
//   in_{a,b,ctrl,valid}_{n,e,s,w}  : mesh requester packets
//   in_ready_{n,e,s,w}             : mesh buffer can accept this cycle
//   host_in_{a,b,ctrl,valid}       : host requester packet
//   host_in_ready                  : host buffer can accept
//   alu_{a,b,ctrl,valid,src}       : issue stage toward the ALU
//   alu_ready                      : ALU consumes the issued packet
//   busy                           : any buffer or the issue stage occupied
// Build option: ARB_HOST_PRIORITY_EN gives the host strict priority over the
// mesh ports; round-robin then runs among N/E/S/W only.
module alu_tile_issue_arbiter #(
    parameter int DATA_W    = 64,
    parameter int CTRL_W    = 16,
    parameter int NUM_PORTS = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_a_n,
    input  logic [DATA_W-1:0] in_a_e,
    input  logic [DATA_W-1:0] in_a_s,
    input  logic [DATA_W-1:0] in_a_w,
    input  logic [DATA_W-1:0] in_b_n,
    input  logic [DATA_W-1:0] in_b_e,
    input  logic [DATA_W-1:0] in_b_s,
    input  logic [DATA_W-1:0] in_b_w,
    input  logic [CTRL_W-1:0] in_ctrl_n,
    input  logic [CTRL_W-1:0] in_ctrl_e,
    input  logic [CTRL_W-1:0] in_ctrl_s,
    input  logic [CTRL_W-1:0] in_ctrl_w,
    input  logic              in_valid_n,
    input  logic              in_valid_e,
    input  logic              in_valid_s,
    input  logic              in_valid_w,
    output logic              in_ready_n,
    output logic              in_ready_e,
    output logic              in_ready_s,
    output logic              in_ready_w,
    input  logic [DATA_W-1:0] host_in_a,
    input  logic [DATA_W-1:0] host_in_b,
    input  logic [CTRL_W-1:0] host_in_ctrl,
    input  logic              host_in_valid,
    output logic              host_in_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic              alu_valid,
    input  logic              alu_ready,
    output logic [2:0]        alu_src,
    output logic              busy
);
    import alu_tile_arb_pkg::*;

    // Buffers and the issue register use the package packet type, so the
    // widths have to agree with the package defaults.
    if (NUM_PORTS != 5) begin : g_bad_ports
        $error("alu_tile_issue_arbiter: NUM_PORTS must be 5");
    end
    if (DATA_W != ARB_DATA_W || CTRL_W != ARB_CTRL_W) begin : g_bad_width
        $error("alu_tile_issue_arbiter: DATA_W/CTRL_W must match alu_tile_arb_pkg");
    end

    logic [4:0] in_valid, in_ready, accept, gnt;
    logic [4:0] hold_valid_q;
    alu_pkt_t   in_pkt     [5];
    alu_pkt_t   hold_pkt_q [5];

    alu_pkt_t   alu_pkt_q;
    logic       alu_valid_q;
    logic [2:0] alu_src_q;
    logic [2:0] rr_ptr_q;

    assign in_valid = {host_in_valid, in_valid_w, in_valid_s, in_valid_e, in_valid_n};
    assign in_pkt[PORT_N]    = {in_a_n, in_b_n, in_ctrl_n};
    assign in_pkt[PORT_E]    = {in_a_e, in_b_e, in_ctrl_e};
    assign in_pkt[PORT_S]    = {in_a_s, in_b_s, in_ctrl_s};
    assign in_pkt[PORT_W]    = {in_a_w, in_b_w, in_ctrl_w};
    assign in_pkt[PORT_HOST] = {host_in_a, host_in_b, host_in_ctrl};

    // Arbitration
    logic [4:0] pick_req, pick_gnt, sel_gnt;
    logic [2:0] pick_idx, sel_idx;
    logic       pick_any, sel_any, upd_ptr, issue_en;

    rr_pick5 u_pick (
        .req_i     (pick_req),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (pick_gnt),
        .gnt_idx_o (pick_idx),
        .any_o     (pick_any)
    );

`ifdef ARB_HOST_PRIORITY_EN
    // Host preempts the mesh; the picker only sees N/E/S/W, and a host
    // grant leaves the mesh rotation where it was.
    logic host_win;
    assign host_win = hold_valid_q[PORT_HOST];
    assign pick_req = {1'b0, hold_valid_q[3:0]};
    assign sel_gnt  = host_win ? 5'b10000 : pick_gnt;
    assign sel_idx  = host_win ? 3'(PORT_HOST) : pick_idx;
    assign sel_any  = host_win | pick_any;
    assign upd_ptr  = !host_win;
`else
    assign pick_req = hold_valid_q;
    assign sel_gnt  = pick_gnt;
    assign sel_idx  = pick_idx;
    assign sel_any  = pick_any;
    assign upd_ptr  = 1'b1;
`endif

    assign issue_en = !alu_valid_q | alu_ready;
    assign gnt      = issue_en ? sel_gnt : '0;
    // A granted buffer drains this edge, so it can take a new packet too.
    assign in_ready = ~hold_valid_q | gnt;
    assign accept   = in_valid & in_ready;

    // Holding buffers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid_q <= '0;
            for (int p = 0; p < 5; p++) hold_pkt_q[p] <= '0;
        end else begin
            for (int p = 0; p < 5; p++) begin
                if (accept[p]) begin
                    hold_valid_q[p] <= 1'b1;
                    hold_pkt_q[p]   <= in_pkt[p];
                end else if (gnt[p]) begin
                    hold_valid_q[p] <= 1'b0;
                end
            end
        end
    end

    // Issue stage; data registers keep their last value when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_pkt_q   <= '0;
            alu_valid_q <= 1'b0;
            alu_src_q   <= 3'(PORT_N);
            rr_ptr_q    <= 3'(PORT_HOST);
        end else if (issue_en) begin
            if (sel_any) begin
                alu_pkt_q   <= hold_pkt_q[sel_idx];
                alu_src_q   <= sel_idx;
                alu_valid_q <= 1'b1;
                if (upd_ptr) rr_ptr_q <= sel_idx;
            end else begin
                alu_valid_q <= 1'b0;
            end
        end
    end

    assign in_ready_n    = in_ready[PORT_N];
    assign in_ready_e    = in_ready[PORT_E];
    assign in_ready_s    = in_ready[PORT_S];
    assign in_ready_w    = in_ready[PORT_W];
    assign host_in_ready = in_ready[PORT_HOST];

    assign alu_a     = alu_pkt_q.a;
    assign alu_b     = alu_pkt_q.b;
    assign alu_ctrl  = alu_pkt_q.ctrl;
    assign alu_valid = alu_valid_q;
    assign alu_src   = alu_src_q;
    assign busy      = (|hold_valid_q) | alu_valid_q;

endmodule

// File: tb/tb_alu_tile_issue_arbiter.sv
// Self-checking bench for alu_tile_issue_arbiter: a fairness vector table,
// hand-written multi-cycle sequences and randomized traffic, all compared
// every cycle against a behavioural model of buffers + issue register.
module tb_alu_tile_issue_arbiter;
    localparam int DW = 64;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] ta [5];
    logic [DW-1:0] tbv [5];
    logic [CW-1:0] tc [5];
    logic          tv [5];
    logic [4:0]    rdy;
    logic          alu_ready;
    logic [DW-1:0] alu_a, alu_b;
    logic [CW-1:0] alu_ctrl;
    logic          alu_valid, busy;
    logic [2:0]    alu_src;

    alu_tile_issue_arbiter #(.DATA_W(DW), .CTRL_W(CW), .NUM_PORTS(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_a_n(ta[0]), .in_a_e(ta[1]), .in_a_s(ta[2]), .in_a_w(ta[3]),
        .in_b_n(tbv[0]), .in_b_e(tbv[1]), .in_b_s(tbv[2]), .in_b_w(tbv[3]),
        .in_ctrl_n(tc[0]), .in_ctrl_e(tc[1]), .in_ctrl_s(tc[2]), .in_ctrl_w(tc[3]),
        .in_valid_n(tv[0]), .in_valid_e(tv[1]), .in_valid_s(tv[2]), .in_valid_w(tv[3]),
        .in_ready_n(rdy[0]), .in_ready_e(rdy[1]), .in_ready_s(rdy[2]), .in_ready_w(rdy[3]),
        .host_in_a(ta[4]), .host_in_b(tbv[4]), .host_in_ctrl(tc[4]),
        .host_in_valid(tv[4]), .host_in_ready(rdy[4]),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_valid(alu_valid),
        .alu_ready(alu_ready), .alu_src(alu_src), .busy(busy)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit            m_hv [5];
    logic [DW-1:0] m_ha [5], m_hb [5];
    logic [CW-1:0] m_hc [5];
    bit            m_av;
    logic [DW-1:0] m_ao, m_bo;
    logic [CW-1:0] m_co;
    int            m_src, m_ptr;

    task automatic m_reset();
        for (int p = 0; p < 5; p++) begin
            m_hv[p] = 0; m_ha[p] = '0; m_hb[p] = '0; m_hc[p] = '0;
        end
        m_av = 0; m_ao = '0; m_bo = '0; m_co = '0; m_src = 0; m_ptr = 4;
    endtask

    // Which held packet would win if the issue stage could take one.
    function automatic int m_winner();
`ifdef ARB_HOST_PRIORITY_EN
        if (m_hv[4]) return 4;
        for (int k = 1; k <= 5; k++) begin
            int idx = (m_ptr + k) % 5;
            if (idx != 4 && m_hv[idx]) return idx;
        end
`else
        for (int k = 1; k <= 5; k++) begin
            int idx = (m_ptr + k) % 5;
            if (m_hv[idx]) return idx;
        end
`endif
        return -1;
    endfunction

    function automatic logic [4:0] m_rdy();
        logic [4:0] r;
        int w = (!m_av || alu_ready) ? m_winner() : -1;
        for (int p = 0; p < 5; p++) r[p] = !m_hv[p] || (w == p);
        return r;
    endfunction

    task automatic m_step();
        bit acc [5];
        bit issue = !m_av || (alu_ready === 1'b1);
        int w = issue ? m_winner() : -1;
        for (int p = 0; p < 5; p++) acc[p] = (tv[p] === 1'b1) && (!m_hv[p] || w == p);
        if (issue) begin
            if (w >= 0) begin
                m_ao = m_ha[w]; m_bo = m_hb[w]; m_co = m_hc[w];
                m_av = 1; m_src = w;
`ifdef ARB_HOST_PRIORITY_EN
                if (w != 4) m_ptr = w;
`else
                m_ptr = w;
`endif
                m_hv[w] = 0;
            end else begin
                m_av = 0;
            end
        end
        for (int p = 0; p < 5; p++) if (acc[p]) begin
            m_hv[p] = 1; m_ha[p] = ta[p]; m_hb[p] = tbv[p]; m_hc[p] = tc[p];
        end
    endtask

    task automatic mcmp();
        bit anyh = 0;
        for (int p = 0; p < 5; p++) anyh |= m_hv[p];
        chk("m_valid", alu_valid, m_av);
        chk("m_a", alu_a, m_ao);
        chk("m_b", alu_b, m_bo);
        chk("m_ctrl", alu_ctrl, m_co);
        chk("m_src", alu_src, m_src);
        chk("m_busy", busy, anyh | m_av);
        chk("m_rdy", rdy, m_rdy());
    endtask

    // One clock: compare at negedge, model advances with the edge.
    task automatic cyc();
        @(negedge clk);
        mcmp();
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic idle();
        for (int p = 0; p < 5; p++) tv[p] = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        #2;
        chk("rst_valid", alu_valid, 0);
        chk("rst_busy", busy, 0);
        m_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_rdy", rdy, 5'h1f);
        chk("rst_src", alu_src, 0);
    endtask

    typedef struct {
        logic [4:0] vmask;
        logic       ardy;
        logic [4:0] exp_rdy;
        logic       exp_av;
        logic [2:0] exp_src;
    } vec_t;

    vec_t vt [13];
    int   exp_pri [3];

    initial begin
        for (int p = 0; p < 5; p++) begin
            ta[p] = '0; tbv[p] = '0; tc[p] = '0; tv[p] = 1'b0;
        end
        alu_ready = 1'b0;

        // Fairness table: all five ports stream, then the ALU stalls.
        vt[0] = '{5'h1f, 1'b1, 5'h1f, 1'b0, 3'd0};
        for (int r = 1; r <= 10; r++)
            vt[r] = '{5'h1f, 1'b1, 5'(1 << ((r - 1) % 5)), 1'b1, 3'((r - 1) % 5)};
        vt[11] = '{5'h1f, 1'b0, 5'h00, 1'b1, 3'd4};
        vt[12] = '{5'h1f, 1'b0, 5'h00, 1'b1, 3'd4};

        do_reset();

        // Single path through the host port
        alu_ready = 1'b1;
        ta[4] = 64'd5; tbv[4] = 64'd7; tc[4] = 16'h0001; tv[4] = 1'b1;
        cyc();
        tv[4] = 1'b0;
        cyc();
        chk("single_valid", alu_valid, 1);
        chk("single_a", alu_a, 5);
        chk("single_b", alu_b, 7);
        chk("single_ctrl", alu_ctrl, 16'h0001);
        chk("single_src", alu_src, 4);
        cyc();
        chk("single_drain", alu_valid, 0);

        // Fairness table
        do_reset();
        for (int p = 0; p < 5; p++) begin
            ta[p] = 64'(p); tbv[p] = 64'(p + 100); tc[p] = 16'(p);
        end
        for (int r = 0; r < 13; r++) begin
            for (int p = 0; p < 5; p++) tv[p] = vt[r].vmask[p];
            alu_ready = vt[r].ardy;
            #1;
            chk("tbl_rdy", rdy, vt[r].exp_rdy);
            cyc();
            chk("tbl_valid", alu_valid, vt[r].exp_av);
            if (vt[r].exp_av) begin
                chk("tbl_src", alu_src, vt[r].exp_src);
                chk("tbl_a", alu_a, 64'(vt[r].exp_src));
            end
        end

        // Backpressure: N and E full while the ALU stalls
        do_reset();
        alu_ready = 1'b0;
        ta[0] = 64'd1; tbv[0] = 64'd11; tc[0] = 16'h10; tv[0] = 1'b1;
        ta[1] = 64'd2; tbv[1] = 64'd12; tc[1] = 16'h20; tv[1] = 1'b1;
        cyc();
        tv[1] = 1'b0;
        ta[0] = 64'd3; tbv[0] = 64'd13; tc[0] = 16'h30;
        cyc();
        idle();
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("bp_rdy", rdy[1:0], 2'b00);
            cyc();
            chk("bp_valid", alu_valid, 1);
            chk("bp_a", alu_a, 1);
        end
        alu_ready = 1'b1;
        cyc();
        chk("bp_src1", alu_src, 1);
        chk("bp_a1", alu_a, 2);
        cyc();
        chk("bp_src2", alu_src, 0);
        chk("bp_a2", alu_a, 3);
        cyc();
        chk("bp_drain", alu_valid, 0);

        // Throughput: W streams 8 back-to-back packets
        do_reset();
        alu_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            ta[3] = 64'(256 + k); tbv[3] = 64'(k); tc[3] = 16'(k); tv[3] = 1'b1;
            #1;
            chk("tp_rdy", rdy[3], 1);
            cyc();
            if (k >= 1) begin
                chk("tp_valid", alu_valid, 1);
                chk("tp_a", alu_a, 64'(256 + k - 1));
            end
        end
        tv[3] = 1'b0;
        cyc();
        chk("tp_last", alu_a, 64'(263));
        chk("tp_last_valid", alu_valid, 1);
        cyc();
        chk("tp_drain", alu_valid, 0);

        // Host priority vs plain round robin
`ifdef ARB_HOST_PRIORITY_EN
        exp_pri = '{4, 0, 2};
`else
        exp_pri = '{0, 2, 4};
`endif
        do_reset();
        alu_ready = 1'b1;
        for (int p = 0; p < 5; p++) ta[p] = 64'(p);
        tv[0] = 1'b1; tv[2] = 1'b1; tv[4] = 1'b1;
        cyc();
        idle();
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("pri_src", alu_src, 64'(exp_pri[i]));
        end

        // Reset mid-traffic: N and host held, issue stage full
        do_reset();
        alu_ready = 1'b0;
        ta[0] = 64'hA; tv[0] = 1'b1;
        ta[4] = 64'hB; tv[4] = 1'b1;
        cyc();
        tv[4] = 1'b0;
        ta[0] = 64'hC;
        cyc();
        idle();
        chk("mid_pre_valid", alu_valid, 1);
        chk("mid_pre_busy", busy, 1);
        do_reset();
        alu_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("mid_noissue", alu_valid, 0);
        end

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < 5; p++) begin
                tv[p]  = ($urandom_range(0, 99) < 45);
                ta[p]  = {$urandom, $urandom};
                tbv[p] = {$urandom, $urandom};
                tc[p]  = 16'($urandom);
            end
            alu_ready = ($urandom_range(0, 99) < 65);
            cyc();
        end
        idle();
        alu_ready = 1'b1;
        for (int i = 0; i < 8; i++) cyc();
        chk("final_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_tile_issue_arbiter.md
Name: alu_tile_issue_arbiter

Overview:
- Shares the single operand-issue port of one ALU tile among five requesters: mesh N, E, S, W and host.
- Each requester has a 1-entry holding buffer with a valid/ready handshake. A round-robin arbiter picks one buffered packet per cycle into a registered issue stage toward the ALU.
- Sits between the tile's NoC input links and the ALU tile datapath, one instance per tile.

Parameters:
- DATA_W, 64, width of operands a and b
- CTRL_W, 16, width of the ctrl/opcode field
- NUM_PORTS, 5, number of requesters; fixed at 5, with elaboration error otherwise

Ports:
- clk  in  1  tile clock
- rst_n  in  1  asynchronous active-low reset
- in_a_{n,e,s,w}  in  DATA_W  operand a per mesh direction
- in_b_{n,e,s,w}  in  DATA_W  operand b per mesh direction
- in_ctrl_{n,e,s,w}  in  CTRL_W  ctrl per mesh direction
- in_valid_{n,e,s,w}  in  1  packet valid per direction
- in_ready_{n,e,s,w}  out  1  buffer can accept this cycle
- host_in_a / host_in_b / host_in_ctrl / host_in_valid  in  DATA_W/DATA_W/CTRL_W/1  host requester
- host_in_ready  out  1  host buffer can accept
- alu_a  out  DATA_W  issued operand a
- alu_b  out  DATA_W  issued operand b
- alu_ctrl  out  CTRL_W  issued ctrl
- alu_valid  out  1  issue stage holds a packet
- alu_ready  in  1  ALU consumes the packet this cycle
- alu_src  out  3  source of the issued packet: 0=N, 1=E, 2=S, 3=W, 4=host
- busy  out  1  any holding buffer or the issue stage is occupied

Behaviour:
- Clock and reset
  - One clock. All state is reset asynchronously on rst_n low and released synchronously.
  - Reset values:
    - all hold_valid = 0, alu_valid = 0
    - alu_a, alu_b, alu_ctrl = 0; alu_src = 0
    - rr_ptr = 4 (so N has highest priority first); busy = 0
  - in_ready_* and host_in_ready are 1 after reset.
- Per-port holding buffer (index p)
  - Accept when in_valid_p and in_ready_p.
  - Payload is captured at that edge and hold_valid_p is set.
  - in_ready_p = !hold_valid_p | grant_p. Accept and grant of the same port in one cycle keep hold_valid_p = 1 with the new payload, giving full throughput.
  - Payload is stable while hold_valid_p = 1 and not granted.
- Issue stage
  - issue_en = !alu_valid | alu_ready.
  - If issue_en and any hold_valid is set:
    - grant exactly one port, chosen round-robin;
    - load alu_a, alu_b, alu_ctrl and alu_src from it;
    - set alu_valid = 1, clear (or refill) that hold, rr_ptr <= granted index.
  - If issue_en and no request: alu_valid <= 0, and the data registers keep their last value.
  - If !issue_en: no grant is made; the issue registers and rr_ptr hold.
- Round-robin rule
  - Search order starts at rr_ptr+1 and wraps from 4 to 0. The first requester found wins.
  - A continuously requesting port waits at most 4 grants.
- Latency and throughput
  - A packet accepted at edge t is visible on alu_* after edge t+1, i.e. 2 cycles minimum.
  - One issue per cycle when alu_ready is held high.
- busy = OR(hold_valid) | alu_valid, registered-state derived.
- Boundary conditions
  - Reset mid-operation: every buffered and issued packet is discarded, with no partial output.
  - All five ports requesting with alu_ready = 0: no state changes; all in_ready = 0 except for empty buffers.
  - A port's in_valid dropping while its buffer is full has no effect.
- No ctrl decoding: packets pass through bit-exact.

Optional Feature:
- ARB_HOST_PRIORITY_EN
  - Defined: the host buffer wins strictly over all mesh ports whenever hold_valid_4 = 1. Round-robin applies only among N/E/S/W; a host grant does not update rr_ptr.
  - Undefined: host is a normal round-robin participant (index 4).

Decomposition:
- Package alu_tile_arb_pkg:
  - port index enum (PORT_N=0 .. PORT_HOST=4), NUM_PORTS;
  - packed struct alu_pkt_t {a, b, ctrl};
  - DATA_W/CTRL_W localparam defaults.
- Sub-module rr_pick5: combinational 5-way round-robin picker.
  - Inputs: req[4:0], ptr[2:0].
  - Outputs: gnt one-hot, gnt_idx, any.
  - Reused for the 4-way mesh case via req[4] masking under the macro.

Test Plan:
- Reset: assert rst_n low mid-traffic (N and host buffered, alu_valid = 1) -> all alu_valid/busy = 0 immediately, all in_ready = 1 after release, no packet ever issued.
- Single path: host_in a=5, b=7, ctrl=16'h0001 valid at edge 0 with alu_ready = 1 -> alu_valid = 1, alu_a = 5, alu_b = 7, alu_src = 4 after edge 1, then alu_valid = 0 after edge 2.
- Fairness: all 5 ports request continuously with a=port index, alu_ready = 1 -> alu_src sequence 0,1,2,3,4,0,1,... with one issue per cycle.
- Backpressure: N and E fill, alu_ready = 0 for 10 cycles -> alu_* stable; in_ready_n = in_ready_e = 0; on alu_ready = 1, N is then E is issued in order with no loss.
- Throughput: W streams 8 packets back-to-back, alu_ready = 1 -> in_ready_w stays 1, 8 consecutive alu_valid cycles with payloads in order.
- ARB_HOST_PRIORITY_EN: N, S and host all request -> host issued first, then N, S; without the macro the order is N, S, host.
